// File: rtl/ghost_route_pkg.sv
// Shared types for the ghost route sequencer: direction keycodes, route table entries,
// sequencer states and the widened absolute-difference helper used by the hit windows.
package ghost_route_pkg;

    typedef enum logic [7:0] {
        KEY_NONE = 8'h00,
        KEY_L    = 8'h04,
        KEY_R    = 8'h07,
        KEY_D    = 8'h16,
        KEY_U    = 8'h1A
    } dir_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        dir_t       dir;
    } waypoint_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        ARM  = 2'd2
    } seq_state_t;

    // Operands are widened to 11 bits first so the difference can never wrap.
    function automatic logic [10:0] absDiff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[10] ? (~d + 11'd1) : d;
    endfunction

endpackage

// File: rtl/ghost_route_seq_if.sv
// Bus between the route sequencer (slave side) and whoever drives ghost position and
// consumes the keycode stream (master side).
interface ghost_route_seq_if #(
    parameter int IDX_W = 5
);
    logic             run;
    logic [9:0]       ghost_x;
    logic [9:0]       ghost_y;
    logic [7:0]       keycode;
    logic             turn_pulse;
    logic [IDX_W-1:0] wp_idx;
    logic [7:0]       lap_cnt;
    logic             stalled;

    modport master (
        output run, ghost_x, ghost_y,
        input  keycode, turn_pulse, wp_idx, lap_cnt, stalled
    );

    modport slave (
        input  run, ghost_x, ghost_y,
        output keycode, turn_pulse, wp_idx, lap_cnt, stalled
    );

endinterface

// File: rtl/ghost_route_rom.sv
// Combinational route table. ROUTE_ID 1 is the left/right mirror of route 0; any other
// ROUTE_ID selects route 0. Indices at or beyond NUM_WP read back as an empty entry.
module ghost_route_rom
    import ghost_route_pkg::*;
#(
    parameter int NUM_WP   = 28,
    parameter int IDX_W    = 5,
    parameter int ROUTE_ID = 0
) (
    input  logic [IDX_W-1:0] idx,
    output waypoint_t        wp
);

    waypoint_t w_base;

    always_comb begin
        w_base = '{10'd0, 10'd0, KEY_NONE};
        case (int'(idx))
            0:       w_base = '{10'd176, 10'd64,  KEY_D};
            1:       w_base = '{10'd176, 10'd112, KEY_R};
            2:       w_base = '{10'd240, 10'd112, KEY_D};
            3:       w_base = '{10'd240, 10'd160, KEY_L};
            4:       w_base = '{10'd192, 10'd160, KEY_D};
            5:       w_base = '{10'd192, 10'd208, KEY_R};
            6:       w_base = '{10'd288, 10'd208, KEY_U};
            7:       w_base = '{10'd288, 10'd112, KEY_R};
            8:       w_base = '{10'd336, 10'd112, KEY_U};
            9:       w_base = '{10'd336, 10'd64,  KEY_L};
            10:      w_base = '{10'd272, 10'd64,  KEY_D};
            11:      w_base = '{10'd272, 10'd160, KEY_R};
            12:      w_base = '{10'd384, 10'd160, KEY_D};
            13:      w_base = '{10'd384, 10'd256, KEY_L};
            14:      w_base = '{10'd320, 10'd256, KEY_D};
            15:      w_base = '{10'd320, 10'd304, KEY_L};
            16:      w_base = '{10'd224, 10'd304, KEY_U};
            17:      w_base = '{10'd224, 10'd256, KEY_L};
            18:      w_base = '{10'd128, 10'd256, KEY_U};
            19:      w_base = '{10'd128, 10'd208, KEY_R};
            20:      w_base = '{10'd160, 10'd208, KEY_U};
            21:      w_base = '{10'd160, 10'd160, KEY_L};
            22:      w_base = '{10'd96,  10'd160, KEY_U};
            23:      w_base = '{10'd96,  10'd112, KEY_R};
            24:      w_base = '{10'd128, 10'd112, KEY_U};
            25:      w_base = '{10'd128, 10'd64,  KEY_R};
            26:      w_base = '{10'd152, 10'd64,  KEY_R};
            27:      w_base = '{10'd176, 10'd64,  KEY_D};
            default: w_base = '{10'd0, 10'd0, KEY_NONE};
        endcase
    end

    // Mirror about x=224 for the alternate route, swapping horizontal turns.
    always_comb begin
        wp = w_base;
        if (ROUTE_ID == 1) begin
            wp.x = 10'd448 - w_base.x;
            if (w_base.dir == KEY_L) begin
                wp.dir = KEY_R;
            end else if (w_base.dir == KEY_R) begin
                wp.dir = KEY_L;
            end
        end
        if (int'(idx) >= NUM_WP) begin
            wp = '{10'd0, 10'd0, KEY_NONE};
        end
    end

endmodule

// File: rtl/ghost_route_seq.sv
// Waypoint sequencer for one ghost: issues a one-frame keycode when the ghost reaches the
// active waypoint. Defining GHOST_STALL_WDOG_EN adds the stall watchdog that re-emits the last keycode.
module ghost_route_seq
    import ghost_route_pkg::*;
#(
    parameter int NUM_WP       = 28,
    parameter int LOOP_START   = 1,
    parameter int TOL          = 2,
    parameter int STALL_FRAMES = 8,
    parameter int IDX_W        = 5,
    parameter int ROUTE_ID     = 0
) (
    input logic              frame_clk,
    input logic              Reset,
    ghost_route_seq_if.slave bus
);

    localparam logic [1:0]       ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]       ST_SEEK  = 2'(SEEK);
    localparam logic [1:0]       ST_ARM   = 2'(ARM);
    localparam logic [10:0]      TOL_W    = 11'(TOL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WP - 1);
    localparam logic [IDX_W-1:0] LOOP_IDX = IDX_W'(LOOP_START);

    if (NUM_WP < 2 || NUM_WP > 2**IDX_W || LOOP_START >= NUM_WP ||
        STALL_FRAMES < 2 || STALL_FRAMES > 16) begin : g_paramCheck
        $error("ghost_route_seq: illegal parameter set");
    end

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_wpIdx;
    logic [7:0]       r_lapCnt;
    logic [7:0]       r_keycode;
    logic             r_turnPulse;
    logic             r_stalled;
    logic [9:0]       r_consX;
    logic [9:0]       r_consY;

    waypoint_t        w_wp;
    logic             w_hit;
    logic             w_outside;
    logic             w_active;
    logic             w_take;
    logic             w_stallFire;
    logic [7:0]       w_stallKey;

    ghost_route_rom #(
        .NUM_WP   (NUM_WP),
        .IDX_W    (IDX_W),
        .ROUTE_ID (ROUTE_ID)
    ) u_rom (
        .idx (r_wpIdx),
        .wp  (w_wp)
    );

    assign w_hit     = (absDiff(bus.ghost_x, w_wp.x) <= TOL_W) &&
                       (absDiff(bus.ghost_y, w_wp.y) <= TOL_W);
    assign w_outside = (absDiff(bus.ghost_x, r_consX) > TOL_W) ||
                       (absDiff(bus.ghost_y, r_consY) > TOL_W);
    assign w_active  = bus.run && (r_state == ST_SEEK || r_state == ST_ARM);
    assign w_take    = bus.run && (r_state == ST_SEEK) && w_hit;

`ifdef GHOST_STALL_WDOG_EN
    localparam logic [3:0] STALL_PRE  = 4'(STALL_FRAMES - 2);
    localparam logic [3:0] STALL_LAST = 4'(STALL_FRAMES - 1);

    logic [9:0] r_prevX;
    logic [9:0] r_prevY;
    logic [3:0] r_stallCnt;
    logic [7:0] r_lastKey;
    logic       w_same;

    assign w_same      = (bus.ghost_x == r_prevX) && (bus.ghost_y == r_prevY);
    assign w_stallFire = w_active && !w_take && w_same &&
                         (r_stallCnt >= STALL_PRE) && (r_lastKey != KEY_NONE);
    assign w_stallKey  = r_lastKey;

    // A fresh hit restarts the stall count; without a remembered key the count parks at its top.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_prevX    <= '0;
            r_prevY    <= '0;
            r_stallCnt <= '0;
            r_lastKey  <= KEY_NONE;
        end else begin
            r_prevX <= bus.ghost_x;
            r_prevY <= bus.ghost_y;
            if (w_take) begin
                r_lastKey  <= w_wp.dir;
                r_stallCnt <= '0;
            end else if (!w_active || !w_same || w_stallFire) begin
                r_stallCnt <= '0;
            end else if (r_stallCnt != STALL_LAST) begin
                r_stallCnt <= r_stallCnt + 4'd1;
            end
        end
    end
`else
    assign w_stallFire = 1'b0;
    assign w_stallKey  = KEY_NONE;
`endif

    // run=0 takes precedence over a hit, so a dropped run never advances the route.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_wpIdx     <= '0;
            r_lapCnt    <= '0;
            r_keycode   <= KEY_NONE;
            r_turnPulse <= 1'b0;
            r_stalled   <= 1'b0;
            r_consX     <= '0;
            r_consY     <= '0;
        end else begin
            r_keycode   <= KEY_NONE;
            r_turnPulse <= 1'b0;
            r_stalled   <= w_stallFire;
            case (r_state)
                ST_IDLE: begin
                    if (bus.run) begin
                        r_state <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (!bus.run) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_keycode   <= w_wp.dir;
                        r_turnPulse <= 1'b1;
                        r_consX     <= w_wp.x;
                        r_consY     <= w_wp.y;
                        r_state     <= ST_ARM;
                        if (r_wpIdx == LAST_IDX) begin
                            r_wpIdx <= LOOP_IDX;
                            if (r_lapCnt != 8'hFF) begin
                                r_lapCnt <= r_lapCnt + 8'd1;
                            end
                        end else begin
                            r_wpIdx <= r_wpIdx + 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (!bus.run) begin
                        r_state <= ST_IDLE;
                    end else if (w_outside) begin
                        r_state <= ST_SEEK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_stallFire) begin
                r_keycode <= w_stallKey;
            end
        end
    end

    assign bus.keycode    = r_keycode;
    assign bus.turn_pulse = r_turnPulse;
    assign bus.wp_idx     = r_wpIdx;
    assign bus.lap_cnt    = r_lapCnt;
    assign bus.stalled    = r_stalled;

endmodule
